// File: rtl/argmax_seq_ctrl.sv
// Sequential argmax over a serial stream of N FP16 logits; reports the winning
// class as one-hot, index and value over a valid/ready result port.
module argmax_seq_ctrl #(
  parameter int N     = 10,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_onehot,
  output logic [IDX_W-1:0] out_idx,
  output logic [15:0]      out_max,
  output logic             frame_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      max_q;
  logic             err_q;
  logic             accept;
  logic             at_end;
  logic             gt;

  // Sign-magnitude ordering: +0 beats -0, NaN/Inf ordered purely by bit fields.
  function automatic logic is_greater(input logic [15:0] a, input logic [15:0] b);
    logic r;
    if (a == b)              r = 1'b0;
    else if (a[15] != b[15]) r = ~a[15];
    else if (!a[15])         r = (a[14:0] > b[14:0]);
    else                     r = (a[14:0] < b[14:0]);
    return r;
  endfunction

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign at_end    = (cnt == IDX_W'(N - 1));
  assign gt        = is_greater(in_data, max_q);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_last ? DONE : COLLECT;
      COLLECT: if (accept && (at_end || in_last)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      max_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            max_q <= in_data;
            idx_q <= '0;
            cnt   <= IDX_W'(1);
            err_q <= in_last;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (gt) begin
              max_q <= in_data;
              idx_q <= cnt;
            end
            if (!at_end) cnt <= cnt + IDX_W'(1);
            // Error when in_last and the final beat position disagree.
            if (at_end != in_last) err_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_onehot = '0;
    if (out_valid) out_onehot[idx_q] = 1'b1;
  end

  assign out_idx   = idx_q;
  assign out_max   = max_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Self-checking bench for argmax_seq_ctrl: directed frames from the test plan
// plus randomized frames checked against a key-based argmax model.
module tb_argmax_seq_ctrl;
  localparam int N     = 10;
  localparam int IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_last;
  logic [15:0]      in_data;
  logic             out_valid, out_ready;
  logic [N-1:0]     out_onehot;
  logic [IDX_W-1:0] out_idx;
  logic [15:0]      out_max;
  logic             frame_err;

  argmax_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
    .out_idx(out_idx), .out_max(out_max), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int accepts = 0;
  int last_acc_cyc = 0;
  logic [15:0] vals [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) accepts <= accepts + 1;
  end

  always @(negedge clk)
    if (out_valid === 1'b1) check("onehot_pop", $countones(out_onehot), 1);

  // Map FP16 bit patterns onto integers whose natural order is the required ordering.
  function automatic int fp_key(input logic [15:0] v);
    int mag;
    mag = int'(v[14:0]);
    return v[15] ? -mag - 1 : mag;
  endfunction

  function automatic int ref_argmax(input int n);
    int best, bi;
    best = fp_key(vals[0]);
    bi = 0;
    for (int i = 1; i < n; i++)
      if (fp_key(vals[i]) > best) begin
        best = fp_key(vals[i]);
        bi = i;
      end
    return bi;
  endfunction

  task automatic send_beat(input logic [15:0] d, input logic l);
    int budget;
    logic acc;
    budget = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 50);
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic check_result(input string tag, input int eidx, input logic eerr);
    logic [N-1:0] eoh;
    eoh = '0;
    eoh[eidx] = 1'b1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_idx"}, out_idx, eidx);
    check({tag, "_max"}, out_max, vals[eidx]);
    check({tag, "_err"}, frame_err, eerr);
    check({tag, "_onehot"}, out_onehot, eoh);
  endtask

  // last_at < 0 means in_last is never raised.
  task automatic run_frame(input string tag, input int n_beats, input int last_at,
                           input int min_gap, input int max_gap, input int hold, input bit b2b);
    int eidx, a0;
    logic eerr;
    for (int k = 0; k < n_beats; k++) begin
      if (max_gap > 0) repeat ($urandom_range(max_gap, min_gap)) begin
        @(posedge clk); #1;
      end
      send_beat(vals[k], (k == last_at));
    end
    eidx = ref_argmax(n_beats);
    eerr = (last_at != N - 1);
    check({tag, "_latency"}, out_valid, 1);
    if (b2b) begin
      check_result(tag, eidx, eerr);
    end else begin
      repeat (hold) begin
        @(negedge clk);
        check_result({tag, "_hold"}, eidx, eerr);
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_result(tag, eidx, eerr);
      a0 = accepts;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_acc_once"}, accepts, a0 + 1);
      check({tag, "_post_valid"}, out_valid, 0);
      check({tag, "_post_ready"}, in_ready, 1);
    end
  endtask

  task automatic fill_random();
    logic [15:0] pool [6];
    pool = '{16'h3C00, 16'hBC00, 16'h0000, 16'h8000, 16'h7C00, 16'hFC00};
    for (int i = 0; i < N; i++)
      vals[i] = $urandom_range(1, 0) ? pool[$urandom_range(5, 0)] : 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, a_start, lat, nb;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_onehot", out_onehot, 0);
    check("rst_idx", out_idx, 0);
    check("rst_max", out_max, 0);
    check("rst_err", frame_err, 0);

    // Basic frame.
    vals = '{16'h3C00, 16'h4000, 16'h3800, 16'h4700, 16'h4200, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    run_frame("basic", N, N - 1, 0, 0, 0, 0);

    // Negative values with a tie: earliest index wins.
    vals = '{16'hBC00, 16'hC000, 16'hB800, 16'hC000, 16'hC000, 16'hC000, 16'hB800,
             16'hC000, 16'hC000, 16'hC000};
    run_frame("neg_tie", N, N - 1, 0, 0, 0, 0);

    // +0 beats -0.
    vals = '{16'h8000, 16'h0000, 16'hBC00, 16'hC000, 16'hB800, 16'hBC00, 16'hC000,
             16'hC400, 16'hBC00, 16'hB800};
    run_frame("zeros", N, N - 1, 0, 0, 0, 0);

    // Backpressure on both sides.
    fill_random();
    run_frame("bp", N, N - 1, 1, 3, 5, 0);

    // Early last on beat 4, max at idx 2.
    vals = '{16'h3C00, 16'h4000, 16'h4500, 16'h3800, 16'h4200, 16'h7C00, 16'h0, 16'h0, 16'h0, 16'h0};
    run_frame("early_last", 5, 4, 0, 0, 1, 0);

    // Missing last on beat 9.
    fill_random();
    run_frame("no_last", N, -1, 0, 0, 0, 0);

    // Reset mid-frame: large values that would win if carried over.
    for (int k = 0; k < 6; k++) send_beat(16'h7BFF, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 check("midrst_still_idle", out_valid, 0);
    vals = '{16'hC000, 16'hC200, 16'hBC00, 16'hC400, 16'hC000, 16'hC000, 16'hC000,
             16'hC000, 16'hC000, 16'hC000};
    run_frame("after_rst", N, N - 1, 0, 0, 0, 0);

    // Back-to-back frames with out_ready tied high.
    out_ready = 1'b1;
    a_start = accepts;
    t0 = 0;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame("b2b", N, N - 1, 0, 0, 0, 1);
      if (f > 0) check("b2b_period", last_acc_cyc - t0, N + 1);
      t0 = last_acc_cyc;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_accepts", accepts - a_start, 3);
    check("b2b_idle", out_valid, 0);

    // Randomized frames.
    for (int f = 0; f < 25; f++) begin
      fill_random();
      lat = $urandom_range(3, 0);
      if (lat == 0) begin
        nb = $urandom_range(N - 2, 0) + 1;
        run_frame("rand", nb, nb - 1, 0, 2, $urandom_range(3, 0), 0);
      end else if (lat == 1) begin
        run_frame("rand", N, -1, 0, 2, $urandom_range(3, 0), 0);
      end else begin
        run_frame("rand", N, N - 1, 0, 2, $urandom_range(3, 0), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
